// File: rtl/prefetcher_data.sv
// rtl/prefetcher_data.sv - data-path burst queue of the AXI read prefetcher
//
// Circular queue of QUEUE_SIZE one-beat slots. Bursts are allocated at the
// tail by prefetch (opcode 1) or master (opcode 2) requests, filled in
// allocation order by DDR beats (opcode 3) and replayed to the master from
// the head once per outstanding promise (opcode 4).
//
// Optional feature macro: PREFETCHER_DATA_ERRCHK_EN (sticky errorCode register;
// when undefined errorCode is tied to 0).
//
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   reqAddr, reqBurstLen   request address and AXI-style length (L = len+1)
//   reqData, reqLast       DDR beat and its final-beat marker
//   reqOpcode              0 nop, 1 prefetch, 2 master req, 3 DDR beat, 4 deliver
//   crs_almostFullSpacer   almost-full threshold in free slots
//   respData, respLast     beat at the read pointer
//   addrHit                reqAddr matches a live burst
//   pr_r_valid             a deliverable beat is present
//   prefetchReqCnt         bursts still flagged prefetch-only
//   almostFull             free slots <= crs_almostFullSpacer
//   errorCode              first nonzero error code, sticky until reset
//   hasOutstanding         some allocated beat has not been written yet

module prefetcher_data #(
    parameter int LOG_QUEUE_SIZE       = 4,
    parameter int LOG_BLOCK_DATA_BYTES = 3,
    parameter int ADDR_BITS            = 64,
    parameter int PROMISE_WIDTH        = 3,
    parameter int BURST_LEN_WIDTH      = 4
) (
    input  logic                                     clk,
    input  logic                                     resetN,
    input  logic [ADDR_BITS-1:0]                     reqAddr,
    input  logic [BURST_LEN_WIDTH-1:0]               reqBurstLen,
    input  logic [8*(1<<LOG_BLOCK_DATA_BYTES)-1:0]   reqData,
    input  logic                                     reqLast,
    input  logic [2:0]                               reqOpcode,
    input  logic [LOG_QUEUE_SIZE-1:0]                crs_almostFullSpacer,
    output logic [8*(1<<LOG_BLOCK_DATA_BYTES)-1:0]   respData,
    output logic                                     respLast,
    output logic                                     addrHit,
    output logic                                     pr_r_valid,
    output logic [LOG_QUEUE_SIZE:0]                  prefetchReqCnt,
    output logic                                     almostFull,
    output logic [2:0]                               errorCode,
    output logic                                     hasOutstanding
);

    localparam int QUEUE_SIZE = 1 << LOG_QUEUE_SIZE;
    localparam int DATA_W     = 8 * (1 << LOG_BLOCK_DATA_BYTES);
    localparam int PW         = LOG_QUEUE_SIZE;
    localparam int CW         = LOG_QUEUE_SIZE + 1;
    localparam int LW         = BURST_LEN_WIDTH + 1;
    localparam logic [PROMISE_WIDTH-1:0] PROMISE_MAX = '1;

    // Per-slot state. slot_final marks the slot that must carry the burst's
    // L-th beat; it is fixed at allocation and drives both the reqLast check
    // and the end-of-burst decision on delivery.
    logic [QUEUE_SIZE-1:0]      slot_valid;
    logic [QUEUE_SIZE-1:0]      slot_dvalid;
    logic [QUEUE_SIZE-1:0]      slot_last;
    logic [QUEUE_SIZE-1:0]      slot_final;
    logic [QUEUE_SIZE-1:0]      slot_head;
    logic [QUEUE_SIZE-1:0]      slot_pref;
    logic [DATA_W-1:0]          slot_data    [QUEUE_SIZE];
    logic [ADDR_BITS-1:0]       slot_addr    [QUEUE_SIZE];
    logic [BURST_LEN_WIDTH-1:0] slot_blen    [QUEUE_SIZE];
    logic [PROMISE_WIDTH-1:0]   slot_promise [QUEUE_SIZE];

    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [PW-1:0] burst_offset;
    logic [PW-1:0] read_ptr;
    logic [CW-1:0] occ;          // allocated slots, 0..QUEUE_SIZE
    logic [CW-1:0] pend_cnt;     // allocated slots still waiting for DDR data
    logic [CW-1:0] pref_cnt;

    logic [LW-1:0]            req_len;
    logic [LW-1:0]            head_len;
    logic [CW-1:0]            free_cnt;
    logic                     can_alloc;
    logic                     hit;
    logic [PW-1:0]            hit_idx;
    logic [PROMISE_WIDTH-1:0] head_promise;
    logic                     rd_valid;
    logic                     alloc_en;
    logic                     deliver_en;
    logic                     free_en;
    logic [QUEUE_SIZE-1:0]    alloc_mask;
    logic [QUEUE_SIZE-1:0]    alloc_final;
    logic [QUEUE_SIZE-1:0]    free_mask;
    logic [2:0]               op_err;

    assign req_len      = LW'(reqBurstLen) + LW'(1);
    assign head_len     = LW'(slot_blen[head_ptr]) + LW'(1);
    assign free_cnt     = CW'(QUEUE_SIZE) - occ;
    assign can_alloc    = 32'(req_len) <= 32'(free_cnt);
    assign head_promise = slot_promise[head_ptr];
    assign rd_valid     = (occ != '0) && (head_promise != '0) && slot_dvalid[read_ptr];

    assign alloc_en   = ((reqOpcode == 3'd1) || (reqOpcode == 3'd2)) && !hit && can_alloc;
    assign deliver_en = (reqOpcode == 3'd4) && rd_valid;
    assign free_en    = deliver_en && slot_final[read_ptr] && (head_promise == PROMISE_WIDTH'(1));

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (!hit && slot_valid[i] && slot_head[i] && (slot_addr[i] == reqAddr)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    // Slot ranges touched by an allocation (from tail) or a burst release
    // (from head), measured as modular distance from the pointer.
    always_comb begin
        logic [PW-1:0] off_a;
        logic [PW-1:0] off_f;
        alloc_mask  = '0;
        alloc_final = '0;
        free_mask   = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            off_a          = PW'(i) - tail_ptr;
            off_f          = PW'(i) - head_ptr;
            alloc_mask[i]  = alloc_en && (32'(off_a) < 32'(req_len));
            alloc_final[i] = (32'(off_a) == 32'(req_len) - 32'd1);
            free_mask[i]   = free_en && (32'(off_f) < 32'(head_len));
        end
    end

    always_comb begin
        op_err = 3'd0;
        case (reqOpcode)
            3'd1: if (!hit && !can_alloc) op_err = 3'd1;
            3'd2: begin
                if (hit) begin
                    if (slot_promise[hit_idx] == PROMISE_MAX) op_err = 3'd4;
                end else if (!can_alloc) begin
                    op_err = 3'd1;
                end
            end
            3'd3: begin
                if (pend_cnt == '0) op_err = 3'd2;
                else if (reqLast != slot_final[burst_offset]) op_err = 3'd5;
            end
            3'd4: if (!rd_valid) op_err = 3'd3;
            default: op_err = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            slot_valid   <= '0;
            slot_dvalid  <= '0;
            slot_last    <= '0;
            slot_final   <= '0;
            slot_head    <= '0;
            slot_pref    <= '0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                slot_data[i]    <= '0;
                slot_addr[i]    <= '0;
                slot_blen[i]    <= '0;
                slot_promise[i] <= '0;
            end
            head_ptr     <= '0;
            tail_ptr     <= '0;
            burst_offset <= '0;
            read_ptr     <= '0;
            occ          <= '0;
            pend_cnt     <= '0;
            pref_cnt     <= '0;
        end else begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                if (alloc_mask[i]) begin
                    slot_valid[i]   <= 1'b1;
                    slot_dvalid[i]  <= 1'b0;
                    slot_last[i]    <= 1'b0;
                    slot_final[i]   <= alloc_final[i];
                    slot_head[i]    <= (PW'(i) == tail_ptr);
                    slot_pref[i]    <= (PW'(i) == tail_ptr) && (reqOpcode == 3'd1);
                    slot_addr[i]    <= reqAddr;
                    slot_blen[i]    <= reqBurstLen;
                    slot_promise[i] <= (reqOpcode == 3'd2) ? PROMISE_WIDTH'(1) : '0;
                end
                if (free_mask[i]) begin
                    slot_valid[i]   <= 1'b0;
                    slot_dvalid[i]  <= 1'b0;
                    slot_last[i]    <= 1'b0;
                    slot_final[i]   <= 1'b0;
                    slot_head[i]    <= 1'b0;
                    slot_pref[i]    <= 1'b0;
                    slot_promise[i] <= '0;
                end
            end

            if (alloc_en) begin
                occ      <= occ + CW'(req_len);
                pend_cnt <= pend_cnt + CW'(req_len);
                tail_ptr <= tail_ptr + PW'(req_len);
                if (reqOpcode == 3'd1) pref_cnt <= pref_cnt + CW'(1);
            end

            // Master hit: add a promise (saturating) and promote a prefetch.
            if ((reqOpcode == 3'd2) && hit) begin
                if (slot_promise[hit_idx] != PROMISE_MAX)
                    slot_promise[hit_idx] <= slot_promise[hit_idx] + PROMISE_WIDTH'(1);
                if (slot_pref[hit_idx]) begin
                    slot_pref[hit_idx] <= 1'b0;
                    pref_cnt           <= pref_cnt - CW'(1);
                end
            end

            if ((reqOpcode == 3'd3) && (pend_cnt != '0)) begin
                slot_data[burst_offset]   <= reqData;
                slot_dvalid[burst_offset] <= 1'b1;
                slot_last[burst_offset]   <= reqLast;
                burst_offset              <= burst_offset + PW'(1);
                pend_cnt                  <= pend_cnt - CW'(1);
            end

            if (deliver_en) begin
                if (!slot_final[read_ptr]) begin
                    read_ptr <= read_ptr + PW'(1);
                end else if (!free_en) begin
                    // More promises left: replay the same burst from its first slot.
                    slot_promise[head_ptr] <= head_promise - PROMISE_WIDTH'(1);
                    read_ptr               <= head_ptr;
                end else begin
                    head_ptr <= head_ptr + PW'(head_len);
                    read_ptr <= head_ptr + PW'(head_len);
                    occ      <= occ - CW'(head_len);
                end
            end
        end
    end

`ifdef PREFETCHER_DATA_ERRCHK_EN
    logic [2:0] err_q;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            err_q <= 3'd0;
        end else if ((err_q == 3'd0) && (op_err != 3'd0)) begin
            err_q <= op_err;
        end
    end
    assign errorCode = err_q;
`else
    logic unused_err;
    assign unused_err = ^op_err;
    assign errorCode  = 3'd0;
`endif

    assign respData       = slot_data[read_ptr];
    assign respLast       = slot_last[read_ptr];
    assign addrHit        = hit;
    assign pr_r_valid     = rd_valid;
    assign prefetchReqCnt = pref_cnt;
    assign almostFull     = 32'(free_cnt) <= 32'(crs_almostFullSpacer);
    assign hasOutstanding = (pend_cnt != '0);

endmodule

// File: tb/tb_prefetcher_data.sv
// tb/tb_prefetcher_data.sv - directed self-checking bench for prefetcher_data
module tb_prefetcher_data;

    logic        clk;
    logic        resetN;
    logic [63:0] reqAddr;
    logic [3:0]  reqBurstLen;
    logic [63:0] reqData;
    logic        reqLast;
    logic [2:0]  reqOpcode;
    logic [3:0]  spacer;
    logic [63:0] respData;
    logic        respLast;
    logic        addrHit;
    logic        pr_r_valid;
    logic [4:0]  prefetchReqCnt;
    logic        almostFull;
    logic [2:0]  errorCode;
    logic        hasOutstanding;

    int total = 0;
    int bad   = 0;

`ifdef PREFETCHER_DATA_ERRCHK_EN
    localparam logic [2:0] E1 = 3'd1, E2 = 3'd2, E3 = 3'd3, E4 = 3'd4, E5 = 3'd5;
`else
    localparam logic [2:0] E1 = 3'd0, E2 = 3'd0, E3 = 3'd0, E4 = 3'd0, E5 = 3'd0;
`endif

    prefetcher_data dut (
        .clk                  (clk),
        .resetN               (resetN),
        .reqAddr              (reqAddr),
        .reqBurstLen          (reqBurstLen),
        .reqData              (reqData),
        .reqLast              (reqLast),
        .reqOpcode            (reqOpcode),
        .crs_almostFullSpacer (spacer),
        .respData             (respData),
        .respLast             (respLast),
        .addrHit              (addrHit),
        .pr_r_valid           (pr_r_valid),
        .prefetchReqCnt       (prefetchReqCnt),
        .almostFull           (almostFull),
        .errorCode            (errorCode),
        .hasOutstanding       (hasOutstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Present one opcode, let it take effect on the next rising edge, return
    // 1 time unit after that edge with the opcode back to nop.
    task automatic step(input logic [2:0] op, input logic [63:0] addr, input logic [3:0] blen,
                        input logic [63:0] data, input logic last);
        reqOpcode   = op;
        reqAddr     = addr;
        reqBurstLen = blen;
        reqData     = data;
        reqLast     = last;
        @(posedge clk);
        #1;
        reqOpcode = 3'd0;
    endtask

    task automatic do_reset();
        reqOpcode = 3'd0;
        resetN    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        reqOpcode = 3'd0; reqAddr = 64'h0; reqBurstLen = 4'd0; reqData = 64'h0; reqLast = 1'b0;
        spacer = 4'd2;
        do_reset();
        total++; if (respData !== 64'h0)     begin bad++; $display("FAIL rst_respData got=%0h want=0", respData); end
        total++; if (respLast !== 1'b0)      begin bad++; $display("FAIL rst_respLast got=%0b want=0", respLast); end
        total++; if (addrHit !== 1'b0)       begin bad++; $display("FAIL rst_addrHit got=%0b want=0", addrHit); end
        total++; if (pr_r_valid !== 1'b0)    begin bad++; $display("FAIL rst_pr_r_valid got=%0b want=0", pr_r_valid); end
        total++; if (prefetchReqCnt !== 5'd0) begin bad++; $display("FAIL rst_prefetchReqCnt got=%0d want=0", prefetchReqCnt); end
        total++; if (almostFull !== 1'b0)    begin bad++; $display("FAIL rst_almostFull got=%0b want=0", almostFull); end
        total++; if (errorCode !== 3'd0)     begin bad++; $display("FAIL rst_errorCode got=%0d want=0", errorCode); end
        total++; if (hasOutstanding !== 1'b0) begin bad++; $display("FAIL rst_hasOutstanding got=%0b want=0", hasOutstanding); end
    endtask

    task automatic test_master_miss();
        for (int i = 0; i < 3; i++) begin
            reqOpcode = 3'd2; reqAddr = 64'hdeadbef0 + 64'(i); reqBurstLen = 4'd2;
            #1;
            total++; if (addrHit !== 1'b0) begin bad++; $display("FAIL miss_hit%0d got=%0b want=0", i, addrHit); end
            step(3'd2, 64'hdeadbef0 + 64'(i), 4'd2, 64'h0, 1'b0);
        end
        total++; if (hasOutstanding !== 1'b1) begin bad++; $display("FAIL miss_outstanding got=%0b want=1", hasOutstanding); end
        total++; if (pr_r_valid !== 1'b0) begin bad++; $display("FAIL miss_pr_r_valid got=%0b want=0", pr_r_valid); end
        step(3'd4, 64'h0, 4'd0, 64'h0, 1'b0);
        total++; if (errorCode !== E3) begin bad++; $display("FAIL empty_deliver_err got=%0d want=%0d", errorCode, E3); end
    endtask

    task automatic test_prefetch_alloc();
        step(3'd1, 64'hdeadbef5, 4'd2, 64'h0, 1'b0);
        step(3'd1, 64'hdeadbef6, 4'd2, 64'h0, 1'b0);
        total++; if (prefetchReqCnt !== 5'd2) begin bad++; $display("FAIL pf_cnt got=%0d want=2", prefetchReqCnt); end
        total++; if (almostFull !== 1'b1) begin bad++; $display("FAIL pf_almostFull got=%0b want=1", almostFull); end
        spacer = 4'd0;
        #1;
        total++; if (almostFull !== 1'b0) begin bad++; $display("FAIL pf_almostFull_sp0 got=%0b want=0", almostFull); end
        spacer = 4'd2;
    endtask

    task automatic test_ddr_fill();
        for (int i = 0; i < 15; i++) begin
            step(3'd3, 64'h0, 4'd0, 64'(16 * (i + 1)), (i % 3) == 2);
            if (i == 13) begin
                total++; if (hasOutstanding !== 1'b1) begin bad++; $display("FAIL fill_outstanding14 got=%0b want=1", hasOutstanding); end
            end
        end
        total++; if (hasOutstanding !== 1'b0) begin bad++; $display("FAIL fill_outstanding15 got=%0b want=0", hasOutstanding); end
        total++; if (pr_r_valid !== 1'b1) begin bad++; $display("FAIL fill_pr_r_valid got=%0b want=1", pr_r_valid); end
    endtask

    task automatic test_deliver();
        for (int i = 0; i < 9; i++) begin
            total++; if (pr_r_valid !== 1'b1) begin bad++; $display("FAIL dlv_valid%0d got=%0b want=1", i, pr_r_valid); end
            total++; if (respData !== 64'(16 * (i + 1))) begin bad++; $display("FAIL dlv_data%0d got=%0h want=%0h", i, respData, 16 * (i + 1)); end
            total++; if (respLast !== ((i % 3) == 2)) begin bad++; $display("FAIL dlv_last%0d got=%0b want=%0b", i, respLast, (i % 3) == 2); end
            step(3'd4, 64'h0, 4'd0, 64'h0, 1'b0);
        end
        total++; if (pr_r_valid !== 1'b0) begin bad++; $display("FAIL dlv_blocked got=%0b want=0", pr_r_valid); end
        total++; if (prefetchReqCnt !== 5'd2) begin bad++; $display("FAIL dlv_pfcnt got=%0d want=2", prefetchReqCnt); end
    endtask

    task automatic test_promise_replay();
        logic [63:0] exp;
        for (int k = 0; k < 4; k++) begin
            reqOpcode = 3'd2; reqAddr = (k < 2) ? 64'hdeadbef5 : 64'hdeadbef6; reqBurstLen = 4'd2;
            #1;
            total++; if (addrHit !== 1'b1) begin bad++; $display("FAIL prm_hit%0d got=%0b want=1", k, addrHit); end
            step(3'd2, reqAddr, 4'd2, 64'h0, 1'b0);
        end
        total++; if (prefetchReqCnt !== 5'd0) begin bad++; $display("FAIL prm_pfcnt got=%0d want=0", prefetchReqCnt); end
        for (int k = 0; k < 12; k++) begin
            exp = (k < 6) ? 64'ha0 + 64'(16 * (k % 3)) : 64'hd0 + 64'(16 * (k % 3));
            total++; if (pr_r_valid !== 1'b1) begin bad++; $display("FAIL rpl_valid%0d got=%0b want=1", k, pr_r_valid); end
            total++; if (respData !== exp) begin bad++; $display("FAIL rpl_data%0d got=%0h want=%0h", k, respData, exp); end
            total++; if (respLast !== ((k % 3) == 2)) begin bad++; $display("FAIL rpl_last%0d got=%0b want=%0b", k, respLast, (k % 3) == 2); end
            step(3'd4, 64'h0, 4'd0, 64'h0, 1'b0);
        end
        total++; if (pr_r_valid !== 1'b0) begin bad++; $display("FAIL rpl_empty_valid got=%0b want=0", pr_r_valid); end
        total++; if (almostFull !== 1'b0) begin bad++; $display("FAIL rpl_empty_af got=%0b want=0", almostFull); end
        reqAddr = 64'hdeadbef5;
        #1;
        total++; if (addrHit !== 1'b0) begin bad++; $display("FAIL rpl_freed_hit got=%0b want=0", addrHit); end
        total++; if (errorCode !== E3) begin bad++; $display("FAIL rpl_err_sticky got=%0d want=%0d", errorCode, E3); end
    endtask

    task automatic test_overflow();
        do_reset();
        step(3'd1, 64'h1000, 4'd13, 64'h0, 1'b0);
        total++; if (almostFull !== 1'b1) begin bad++; $display("FAIL ovf_af14 got=%0b want=1", almostFull); end
        reqOpcode = 3'd2; reqAddr = 64'h2000; reqBurstLen = 4'd2;
        #1;
        total++; if (addrHit !== 1'b0) begin bad++; $display("FAIL ovf_hit got=%0b want=0", addrHit); end
        step(3'd2, 64'h2000, 4'd2, 64'h0, 1'b0);
        total++; if (errorCode !== E1) begin bad++; $display("FAIL ovf_err got=%0d want=%0d", errorCode, E1); end
        total++; if (prefetchReqCnt !== 5'd1) begin bad++; $display("FAIL ovf_pfcnt got=%0d want=1", prefetchReqCnt); end
        spacer = 4'd1;
        reqAddr = 64'h2000;
        #1;
        total++; if (almostFull !== 1'b0) begin bad++; $display("FAIL ovf_occ_unchanged got=%0b want=0", almostFull); end
        total++; if (addrHit !== 1'b0) begin bad++; $display("FAIL ovf_not_alloc got=%0b want=0", addrHit); end
        spacer = 4'd2;
        total++; if (hasOutstanding !== 1'b1) begin bad++; $display("FAIL ovf_outstanding got=%0b want=1", hasOutstanding); end
        // Asynchronous reset in the middle of a burst clears state at once.
        resetN = 1'b0;
        #1;
        total++; if (hasOutstanding !== 1'b0) begin bad++; $display("FAIL async_rst_outstanding got=%0b want=0", hasOutstanding); end
        total++; if (prefetchReqCnt !== 5'd0) begin bad++; $display("FAIL async_rst_pfcnt got=%0d want=0", prefetchReqCnt); end
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic test_errors();
        do_reset();
        step(3'd3, 64'h0, 4'd0, 64'h77, 1'b1);
        total++; if (errorCode !== E2) begin bad++; $display("FAIL err2 got=%0d want=%0d", errorCode, E2); end
        total++; if (pr_r_valid !== 1'b0) begin bad++; $display("FAIL err2_valid got=%0b want=0", pr_r_valid); end

        do_reset();
        step(3'd2, 64'h3000, 4'd1, 64'h0, 1'b0);
        step(3'd3, 64'h0, 4'd0, 64'h33, 1'b1);
        total++; if (errorCode !== E5) begin bad++; $display("FAIL err5 got=%0d want=%0d", errorCode, E5); end
        total++; if (hasOutstanding !== 1'b1) begin bad++; $display("FAIL err5_outstanding got=%0b want=1", hasOutstanding); end

        do_reset();
        step(3'd2, 64'h40, 4'd0, 64'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(3'd2, 64'h40, 4'd0, 64'h0, 1'b0);
        total++; if (errorCode !== 3'd0) begin bad++; $display("FAIL sat_noerr got=%0d want=0", errorCode); end
        step(3'd2, 64'h40, 4'd0, 64'h0, 1'b0);
        total++; if (errorCode !== E4) begin bad++; $display("FAIL err4 got=%0d want=%0d", errorCode, E4); end
        step(3'd3, 64'h0, 4'd0, 64'h55, 1'b1);
        for (int i = 0; i < 7; i++) begin
            total++; if (pr_r_valid !== 1'b1) begin bad++; $display("FAIL sat_valid%0d got=%0b want=1", i, pr_r_valid); end
            total++; if (respData !== 64'h55) begin bad++; $display("FAIL sat_data%0d got=%0h want=55", i, respData); end
            step(3'd4, 64'h0, 4'd0, 64'h0, 1'b0);
        end
        total++; if (pr_r_valid !== 1'b0) begin bad++; $display("FAIL sat_done got=%0b want=0", pr_r_valid); end
    endtask

    initial begin
        resetN = 1'b0;
        test_reset();
        test_master_miss();
        test_prefetch_alloc();
        test_ddr_fill();
        test_deliver();
        test_promise_replay();
        test_overflow();
        test_errors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
